player_mover: RTL



---
 rtl/player_mover.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/player_mover.sv
// player_mover: movement stage of the player sprite.
//
// Converts each rising edge of the divided move clock into a one-cycle tick
// in the clk_in domain. On every tick it steps the player position by STEP
// pixels towards the highest-priority held button (up > down > left > right).
// Screen coordinates are used, so "up" decreases y.
//
// Optional feature macro: PLAYER_WRAP_EN
//   defined   -> toroidal playfield, position wraps; the EDGE state is unused
//   undefined -> position clamps at 0 / MAX and the FSM pins in EDGE
//
// Ports:
//   clk_in      system clock
//   reset       asynchronous, active-high reset
//   move_clk    divided move clock (asynchronous level)
//   btn_up/down/left/right  raw active-high buttons (asynchronous)
//   pos_x/pos_y player position (10 bit each)
//   dir         last heading: 00 up, 01 down, 10 left, 11 right
//   moving      high while the FSM is in MOVE
//   at_edge     last executed step was clamped or wrapped at a boundary
//   step_cnt    executed steps, saturating at 16'hFFFF
module player_mover #(
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479,
    parameter int X_INIT = 320,
    parameter int Y_INIT = 240,
    parameter int STEP   = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        move_clk,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [1:0]  dir,
    output logic        moving,
    output logic        at_edge,
    output logic [15:0] step_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MOVE = 2'b01,
        ST_EDGE = 2'b10
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    // 11-bit working constants so pos + STEP can never overflow
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] X_MAX_W  = 11'(X_MAX);
    localparam logic [10:0] Y_MAX_W  = 11'(Y_MAX);
    localparam logic [10:0] X_SPAN_W = 11'(X_MAX + 1);
    localparam logic [10:0] Y_SPAN_W = 11'(Y_MAX + 1);

`ifdef PLAYER_WRAP_EN
    localparam logic CLAMP_EN_C = 1'b0;
`else
    localparam logic CLAMP_EN_C = 1'b1;
`endif

    logic        mclk_s1_r, mclk_s2_r, mclk_hist_r;
    logic [3:0]  btn_s1_r, btn_s2_r;
    state_t      state_r, state_nxt_s;
    logic [9:0]  pos_x_r, pos_y_r;
    logic [1:0]  dir_r;
    logic        moving_r, at_edge_r;
    logic [15:0] step_cnt_r;

    logic        tick_s;
    logic        req_vld_s;
    logic [1:0]  req_dir_s;
    logic [10:0] px_ext_s, py_ext_s, nx_s, ny_s;
    logic        hit_s;
    logic        do_step_s;

    // Synchronizers for move_clk (plus edge history) and the four buttons
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            mclk_s1_r   <= 1'b0;
            mclk_s2_r   <= 1'b0;
            mclk_hist_r <= 1'b0;
            btn_s1_r    <= 4'b0000;
            btn_s2_r    <= 4'b0000;
        end else begin
            mclk_s1_r   <= move_clk;
            mclk_s2_r   <= mclk_s1_r;
            mclk_hist_r <= mclk_s2_r;
            btn_s1_r    <= {btn_up, btn_down, btn_left, btn_right};
            btn_s2_r    <= btn_s1_r;
        end
    end

    assign tick_s = mclk_s2_r & ~mclk_hist_r;

    // Priority decode of the synchronized buttons: up > down > left > right
    always_comb begin
        req_vld_s = |btn_s2_r;
        req_dir_s = DIR_RIGHT;
        if (btn_s2_r[3]) begin
            req_dir_s = DIR_UP;
        end else if (btn_s2_r[2]) begin
            req_dir_s = DIR_DOWN;
        end else if (btn_s2_r[1]) begin
            req_dir_s = DIR_LEFT;
        end else begin
            req_dir_s = DIR_RIGHT;
        end
    end

    // Candidate position for a step in the requested direction, with boundary handling
    always_comb begin
        px_ext_s = {1'b0, pos_x_r};
        py_ext_s = {1'b0, pos_y_r};
        nx_s     = px_ext_s;
        ny_s     = py_ext_s;
        hit_s    = 1'b0;
        case (req_dir_s)
            DIR_UP: begin
                if (py_ext_s < STEP_W) begin
                    hit_s = 1'b1;
                    ny_s  = CLAMP_EN_C ? 11'd0 : (py_ext_s + Y_SPAN_W - STEP_W);
                end else begin
                    ny_s  = py_ext_s - STEP_W;
                end
            end
            DIR_DOWN: begin
                if ((py_ext_s + STEP_W) > Y_MAX_W) begin
                    hit_s = 1'b1;
                    ny_s  = CLAMP_EN_C ? Y_MAX_W : (py_ext_s + STEP_W - Y_SPAN_W);
                end else begin
                    ny_s  = py_ext_s + STEP_W;
                end
            end
            DIR_LEFT: begin
                if (px_ext_s < STEP_W) begin
                    hit_s = 1'b1;
                    nx_s  = CLAMP_EN_C ? 11'd0 : (px_ext_s + X_SPAN_W - STEP_W);
                end else begin
                    nx_s  = px_ext_s - STEP_W;
                end
            end
            DIR_RIGHT: begin
                if ((px_ext_s + STEP_W) > X_MAX_W) begin
                    hit_s = 1'b1;
                    nx_s  = CLAMP_EN_C ? X_MAX_W : (px_ext_s + STEP_W - X_SPAN_W);
                end else begin
                    nx_s  = px_ext_s + STEP_W;
                end
            end
            default: begin
                nx_s  = px_ext_s;
                ny_s  = py_ext_s;
                hit_s = 1'b0;
            end
        endcase
    end

    // Next-state logic; decides whether this tick executes a step
    always_comb begin
        state_nxt_s = state_r;
        do_step_s   = 1'b0;
        if (tick_s) begin
            case (state_r)
                ST_IDLE, ST_MOVE: begin
                    if (req_vld_s) begin
                        do_step_s = 1'b1;
                    end else begin
                        do_step_s = 1'b0;
                    end
                end
                ST_EDGE: begin
                    // dir_r is the heading that pinned us, so the same request is blocked
                    if (req_vld_s && (req_dir_s != dir_r)) begin
                        do_step_s = 1'b1;
                    end else begin
                        do_step_s = 1'b0;
                    end
                end
                default: begin
                    do_step_s = 1'b0;
                end
            endcase
            if (!req_vld_s) begin
                state_nxt_s = ST_IDLE;
            end else if (do_step_s) begin
                state_nxt_s = (hit_s & CLAMP_EN_C) ? ST_EDGE : ST_MOVE;
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            pos_x_r    <= 10'(X_INIT);
            pos_y_r    <= 10'(Y_INIT);
            dir_r      <= DIR_UP;
            moving_r   <= 1'b0;
            at_edge_r  <= 1'b0;
            step_cnt_r <= 16'd0;
        end else begin
            state_r  <= state_nxt_s;
            moving_r <= (state_nxt_s == ST_MOVE);
            if (do_step_s) begin
                pos_x_r   <= nx_s[9:0];
                pos_y_r   <= ny_s[9:0];
                dir_r     <= req_dir_s;
                at_edge_r <= hit_s;
                if (step_cnt_r != 16'hFFFF) begin
                    step_cnt_r <= step_cnt_r + 16'd1;
                end
            end
        end
    end

    assign pos_x    = pos_x_r;
    assign pos_y    = pos_y_r;
    assign dir      = dir_r;
    assign moving   = moving_r;
    assign at_edge  = at_edge_r;
    assign step_cnt = step_cnt_r;

endmodule
